lsu_split_unit: RTL and testbench
=================================

# lsu_split_unit

Parametrised load/store unit that sits between the multicycle core datapath and the native valid/ready memory bus. It accepts one byte, halfword or word access at a time and performs the lane alignment (shift, strobe generation, sign/zero extension). Unlike the fixed alignment logic in the core, it handles accesses that cross a word boundary: it either splits them into two bus beats and merges the result, or rejects them with an error, depending on a parameter.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two beats; 0 = reject them with rsp_err.
- SKIP_EMPTY_BEAT, 1, 1 = never issue a store beat whose strobe is 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE; the request is accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_signed  in  1  load sign-extend (byte/half only).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; holds its value until the next load response.
- rsp_err  out  1  misaligned-reject flag, valid with rsp_valid.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus beat done; may be high in the same cycle mem_valid rises.
- mem_addr  out  ADDR_WIDTH  word-aligned (bits [1:0] = 0).
- mem_wstrb  out  4  byte strobes; 0 for loads.
- mem_wdata  out  32  lane-positioned store data.
- mem_rdata  in  32  read data, valid while mem_ready is high.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- On accept, latch addr, size, we, signed and wdata.
  - off = addr[1:0]; nbytes = 1/2/4.
  - cross = (off + nbytes > 4).
- Aligned (cross = 0): IDLE -> BEAT0 -> RESP.
  - mem_addr = addr & ~3.
  - Strobe = size mask << off.
  - wdata = req_wdata << 8*off.
- Crossing with ALLOW_MISALIGNED = 1: IDLE -> BEAT0 -> BEAT1 -> RESP.
  - Form a 64-bit window: mask8 = sizemask << off; data64 = wdata << 8*off.
  - BEAT0 uses addr & ~3 with the low halves; BEAT1 uses (addr & ~3) + 4 (wrapping) with the high halves.
- Crossing with ALLOW_MISALIGNED = 0: IDLE -> RESP with rsp_err = 1. No bus beat is issued and rsp_rdata is unchanged.
- Loads:
  - Each beat's mem_rdata is captured on mem_ready into the low or high word of a 64-bit buffer.
  - Result = buffer >> 8*off, truncated to nbytes, then sign- or zero-extended.
- SKIP_EMPTY_BEAT: a store beat with a zero strobe is not issued. This cannot occur for a legal crossing access; it guards size = 3 aliasing.
- In BEATn, mem_valid stays high until mem_ready is sampled high. Address, strobe and data are stable throughout.
- A byte access never crosses. A halfword crosses only at off = 3. A word crosses at off = 1, 2 or 3.
- Reset values:
  - State IDLE.
  - mem_valid 0, mem_wstrb 0, mem_addr 0, mem_wdata 0.
  - rsp_valid 0, rsp_err 0, rsp_rdata 0.
  - req_ready 1 from the first cycle after reset.
- Reset mid-operation aborts the access. mem_valid drops at that edge and no response is produced.

## Timing
- Accept at edge 0. mem_valid is high from cycle 1.
- With zero-wait memory (mem_ready high in the same cycle as mem_valid):
  - Aligned: rsp_valid in cycle 2.
  - Crossing: BEAT1 in cycle 2, rsp_valid in cycle 3.
- Each memory wait cycle adds one cycle.
- Rejected misaligned access: rsp_valid in cycle 1.
- Between beats, mem_valid stays high. The address and strobe switch on the edge that samples mem_ready for BEAT0.
- rsp_valid is high for exactly one cycle. req_ready returns high in the cycle after RESP, so the minimum spacing between accepts is 3 cycles for an aligned access.
- req_* inputs are ignored outside IDLE.
- mem_ready while mem_valid is low is ignored.

## Test plan
- Aligned word load at 0x100, mem_rdata = 0xDEADBEEF with zero wait:
  - One beat, mem_addr 0x100.
  - rsp_rdata 0xDEADBEEF and rsp_valid in cycle 2.
- Signed byte load at 0x103 with word 0x80FF_FFFF:
  - Expect rsp_rdata 0xFFFF_FF80.
  - The same access unsigned returns 0x0000_0080.
- Misaligned word store 0x11223344 at 0x202:
  - Beat 0: addr 0x200, wstrb 1100, wdata 0x3344_xxxx.
  - Beat 1: addr 0x204, wstrb 0011, wdata 0xxxxx_1122.
  - One rsp_valid, rsp_err 0.
- Misaligned halfword load at 0xFFFF_FFFF (wrap):
  - Beat 0 addr 0xFFFF_FFFC with rdata 0xAB00_0000.
  - Beat 1 addr 0x0 with rdata 0x0000_00CD.
  - Unsigned result 0x0000_CDAB.
  - Add 2 wait cycles per beat; rsp_valid moves from cycle 3 to cycle 7.
- With ALLOW_MISALIGNED = 0, word load at 0x5:
  - mem_valid never rises.
  - rsp_valid with rsp_err = 1 in cycle 1; rsp_rdata keeps its previous value.
- Assert resetn = 0 during BEAT1 of a split store:
  - mem_valid is 0 after that edge, no rsp_valid, req_ready is 1 after reset is released.
  - The next aligned access completes normally.

Source files
------------

// File: rtl/lsu_split_unit.sv
// Load/store alignment unit between the core datapath and the valid/ready memory bus.
// Word-crossing accesses are either split into two bus beats or rejected, per ALLOW_MISALIGNED.
module lsu_split_unit #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter bit          SKIP_EMPTY_BEAT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [1:0]              off_q;
  logic [1:0]              size_q;
  logic                    we_q;
  logic                    sgn_q;
  logic                    cross_q;
  logic [3:0]              strb_hi_q;
  logic [31:0]             data_hi_q;
  logic [31:0]             buf_lo_q;

  logic                    mem_valid_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [3:0]              mem_wstrb_q;
  logic [31:0]             mem_wdata_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic [31:0]             rsp_rdata_q;

  logic [1:0]              req_off;
  logic [1:0]              req_sz;
  logic [3:0]              req_smask;
  logic [7:0]              req_mask8;
  logic [63:0]             req_data64;
  logic                    req_cross;
  logic [ADDR_WIDTH-1:0]   req_base;
  logic                    need_beat1;
  logic [63:0]             src64;
  logic [31:0]             sh32;
  logic [31:0]             load_res;

  // Request decode: 64-bit byte window spanning the addressed word and the next one.
  always_comb begin
    req_off   = req_addr[1:0];
    req_sz    = (req_size == 2'd3) ? 2'd2 : req_size;
    unique case (req_sz)
      2'd0:    req_smask = 4'b0001;
      2'd1:    req_smask = 4'b0011;
      default: req_smask = 4'b1111;
    endcase
    req_mask8  = {4'b0000, req_smask} << req_off;
    req_data64 = {32'h0, req_wdata} << {req_off, 3'b000};
    req_cross  = |req_mask8[7:4];
    req_base   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  end

  assign need_beat1 = cross_q && !(SKIP_EMPTY_BEAT && we_q && (strb_hi_q == '0));

  // Merge the incoming beat with any captured low word, then align and extend.
  always_comb begin
    src64 = (state_q == BEAT1) ? {mem_rdata, buf_lo_q} : {32'h0, mem_rdata};
    sh32  = 32'(src64 >> {off_q, 3'b000});
    unique case (size_q)
      2'd0:    load_res = {{24{sgn_q & sh32[7]}}, sh32[7:0]};
      2'd1:    load_res = {{16{sgn_q & sh32[15]}}, sh32[15:0]};
      default: load_res = sh32;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      cross_q     <= 1'b0;
      strb_hi_q   <= '0;
      data_hi_q   <= '0;
      buf_lo_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            base_q    <= req_base;
            off_q     <= req_off;
            size_q    <= req_sz;
            we_q      <= req_we;
            sgn_q     <= req_signed;
            cross_q   <= req_cross;
            strb_hi_q <= req_we ? req_mask8[7:4] : 4'b0000;
            data_hi_q <= req_data64[63:32];
            if (req_cross && !ALLOW_MISALIGNED) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= BEAT0;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= req_base;
              mem_wstrb_q <= req_we ? req_mask8[3:0] : 4'b0000;
              mem_wdata_q <= req_data64[31:0];
            end
          end
        end
        BEAT0: begin
          if (mem_valid_q && mem_ready) begin
            buf_lo_q <= mem_rdata;
            if (need_beat1) begin
              state_q     <= BEAT1;
              mem_addr_q  <= base_q + ADDR_WIDTH'(4);
              mem_wstrb_q <= strb_hi_q;
              mem_wdata_q <= data_hi_q;
            end else begin
              state_q     <= RESP;
              mem_valid_q <= 1'b0;
              mem_wstrb_q <= '0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              if (!we_q) rsp_rdata_q <= load_res;
            end
          end
        end
        BEAT1: begin
          if (mem_valid_q && mem_ready) begin
            state_q     <= RESP;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            if (!we_q) rsp_rdata_q <= load_res;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          rsp_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_split_unit.sv
// Directed bench for lsu_split_unit: a split-capable instance plus a reject-mode instance.
module tb_lsu_split_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        req_valid_b, req_ready_b, req_we_b, req_signed_b;
  logic [1:0]  req_size_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;
  logic        mem_valid_b, mem_ready_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [3:0]  mem_wstrb_b;

  int total = 0;
  int bad = 0;

  lsu_split_unit dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_split_unit #(.ALLOW_MISALIGNED(1'b0)) dut_rej (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b), .req_size(req_size_b),
    .req_signed(req_signed_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .mem_valid(mem_valid_b), .mem_ready(mem_ready_b), .mem_addr(mem_addr_b),
    .mem_wstrb(mem_wstrb_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Memory model: tb_wait wait cycles per beat, rdata chosen by address.
  int          tb_wait = 0;
  int          wcnt = 0;
  logic [31:0] rd_addr1, rd_data1, rd_data0, rdata_b;
  assign mem_ready   = mem_valid && (wcnt == tb_wait);
  assign mem_rdata   = (mem_addr == rd_addr1) ? rd_data1 : rd_data0;
  assign mem_ready_b = mem_valid_b;
  assign mem_rdata_b = rdata_b;

  always @(posedge clk) begin
    if (!mem_valid || mem_ready) wcnt <= 0;
    else                         wcnt <= wcnt + 1;
  end

  logic [31:0] log_addr [256];
  logic [3:0]  log_strb [256];
  logic [31:0] log_wdata[256];
  int nbeat = 0;
  int nvalid_b = 0;
  always @(posedge clk) begin
    if (resetn && mem_valid && mem_ready) begin
      log_addr[nbeat[7:0]]  <= mem_addr;
      log_strb[nbeat[7:0]]  <= mem_wstrb;
      log_wdata[nbeat[7:0]] <= mem_wdata;
      nbeat <= nbeat + 1;
    end
    if (mem_valid_b) nvalid_b <= nvalid_b + 1;
  end

  logic cyc1_ready, cyc1_mvalid;

  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err);
    int n;
    lat = -1; rdata = 32'h0; err = 1'b0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    cyc1_ready = req_ready; cyc1_mvalid = mem_valid;
    for (int c = 1; c <= 60; c++) begin
      if (rsp_valid) begin lat = c; rdata = rsp_rdata; err = rsp_err; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_access_b(input logic [1:0] size, input logic [31:0] addr,
                             output int lat, output logic [31:0] rdata, output logic err);
    lat = -1; rdata = 32'h0; err = 1'b0;
    @(negedge clk);
    req_valid_b = 1'b1; req_we_b = 1'b0; req_size_b = size; req_signed_b = 1'b0;
    req_addr_b = addr; req_wdata_b = 32'h0;
    @(negedge clk);
    req_valid_b = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (rsp_valid_b) begin lat = c; rdata = rsp_rdata_b; err = rsp_err_b; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL reset_mem_wstrb got=%b exp=0000", mem_wstrb); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
  endtask

  task automatic test_aligned_load();
    int lat, base; logic [31:0] rd; logic er;
    tb_wait = 0; rd_addr1 = 32'h100; rd_data1 = 32'hDEADBEEF; rd_data0 = 32'h0;
    base = nbeat;
    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er);
    total++; if (lat !== 2) begin bad++; $display("FAIL aligned_lat got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL aligned_rdata got=%h exp=deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL aligned_err got=%b exp=0", er); end
    total++; if (nbeat - base !== 1) begin bad++; $display("FAIL aligned_beats got=%0d exp=1", nbeat - base); end
    total++; if (log_addr[base[7:0]] !== 32'h100) begin bad++; $display("FAIL aligned_addr got=%h exp=100", log_addr[base[7:0]]); end
    total++; if (log_strb[base[7:0]] !== 4'h0) begin bad++; $display("FAIL aligned_load_strb got=%b exp=0000", log_strb[base[7:0]]); end
    total++; if (cyc1_mvalid !== 1'b1) begin bad++; $display("FAIL aligned_mvalid_c1 got=%b exp=1", cyc1_mvalid); end
    total++; if (cyc1_ready !== 1'b0) begin bad++; $display("FAIL aligned_ready_c1 got=%b exp=0", cyc1_ready); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_one_cycle got=%b exp=0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_resp got=%b exp=1", req_ready); end
  endtask

  task automatic test_signed_byte();
    int lat; logic [31:0] rd; logic er;
    tb_wait = 0; rd_addr1 = 32'h100; rd_data1 = 32'h80FFFFFF;
    do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, lat, rd, er);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL sbyte_rdata got=%h exp=ffffff80", rd); end
    total++; if (lat !== 2) begin bad++; $display("FAIL sbyte_lat got=%0d exp=2", lat); end
    do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, lat, rd, er);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL ubyte_rdata got=%h exp=00000080", rd); end
  endtask

  task automatic test_store();
    int lat, base, b1; logic [31:0] rd; logic er;
    tb_wait = 0;
    base = nbeat; b1 = base + 1;
    do_access(1'b1, 2'd2, 1'b0, 32'h202, 32'h11223344, lat, rd, er);
    total++; if (lat !== 3) begin bad++; $display("FAIL split_st_lat got=%0d exp=3", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL split_st_err got=%b exp=0", er); end
    total++; if (nbeat - base !== 2) begin bad++; $display("FAIL split_st_beats got=%0d exp=2", nbeat - base); end
    total++; if (log_addr[base[7:0]] !== 32'h200) begin bad++; $display("FAIL split_b0_addr got=%h exp=200", log_addr[base[7:0]]); end
    total++; if (log_strb[base[7:0]] !== 4'b1100) begin bad++; $display("FAIL split_b0_strb got=%b exp=1100", log_strb[base[7:0]]); end
    total++; if (log_wdata[base[7:0]][31:16] !== 16'h3344) begin bad++; $display("FAIL split_b0_wdata got=%h exp=3344xxxx", log_wdata[base[7:0]]); end
    total++; if (log_addr[b1[7:0]] !== 32'h204) begin bad++; $display("FAIL split_b1_addr got=%h exp=204", log_addr[b1[7:0]]); end
    total++; if (log_strb[b1[7:0]] !== 4'b0011) begin bad++; $display("FAIL split_b1_strb got=%b exp=0011", log_strb[b1[7:0]]); end
    total++; if (log_wdata[b1[7:0]][15:0] !== 16'h1122) begin bad++; $display("FAIL split_b1_wdata got=%h exp=xxxx1122", log_wdata[b1[7:0]]); end
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL store_keeps_rdata got=%h exp=00000080", rd); end
    base = nbeat;
    do_access(1'b1, 2'd1, 1'b0, 32'h302, 32'h1234BEEF, lat, rd, er);
    total++; if (lat !== 2) begin bad++; $display("FAIL half_st_lat got=%0d exp=2", lat); end
    total++; if (log_addr[base[7:0]] !== 32'h300) begin bad++; $display("FAIL half_st_addr got=%h exp=300", log_addr[base[7:0]]); end
    total++; if (log_strb[base[7:0]] !== 4'b1100) begin bad++; $display("FAIL half_st_strb got=%b exp=1100", log_strb[base[7:0]]); end
    total++; if (log_wdata[base[7:0]] !== 32'hBEEF0000) begin bad++; $display("FAIL half_st_wdata got=%h exp=beef0000", log_wdata[base[7:0]]); end
    base = nbeat;
    do_access(1'b1, 2'd0, 1'b0, 32'h301, 32'h000000A5, lat, rd, er);
    total++; if (log_strb[base[7:0]] !== 4'b0010) begin bad++; $display("FAIL byte_st_strb got=%b exp=0010", log_strb[base[7:0]]); end
    total++; if (log_wdata[base[7:0]] !== 32'h0000A500) begin bad++; $display("FAIL byte_st_wdata got=%h exp=0000a500", log_wdata[base[7:0]]); end
  endtask

  task automatic test_wrap();
    int lat, base, b1; logic [31:0] rd; logic er;
    rd_addr1 = 32'h0; rd_data1 = 32'h000000CD; rd_data0 = 32'hAB000000;
    tb_wait = 0;
    base = nbeat; b1 = base + 1;
    do_access(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, lat, rd, er);
    total++; if (lat !== 3) begin bad++; $display("FAIL wrap_lat got=%0d exp=3", lat); end
    total++; if (rd !== 32'h0000CDAB) begin bad++; $display("FAIL wrap_rdata got=%h exp=0000cdab", rd); end
    total++; if (log_addr[base[7:0]] !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_b0_addr got=%h exp=fffffffc", log_addr[base[7:0]]); end
    total++; if (log_addr[b1[7:0]] !== 32'h0) begin bad++; $display("FAIL wrap_b1_addr got=%h exp=0", log_addr[b1[7:0]]); end
    tb_wait = 2;
    do_access(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, lat, rd, er);
    total++; if (lat !== 7) begin bad++; $display("FAIL wrap_wait_lat got=%0d exp=7", lat); end
    total++; if (rd !== 32'h0000CDAB) begin bad++; $display("FAIL wrap_wait_rdata got=%h exp=0000cdab", rd); end
    tb_wait = 0;
    do_access(1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, lat, rd, er);
    total++; if (rd !== 32'hFFFFCDAB) begin bad++; $display("FAIL wrap_signed got=%h exp=ffffcdab", rd); end
  endtask

  task automatic test_reject();
    int lat, nv; logic [31:0] rd; logic er;
    rdata_b = 32'h5A5A1234;
    do_access_b(2'd2, 32'h8, lat, rd, er);
    total++; if (rd !== 32'h5A5A1234) begin bad++; $display("FAIL rej_prev_rdata got=%h exp=5a5a1234", rd); end
    nv = nvalid_b;
    do_access_b(2'd2, 32'h5, lat, rd, er);
    total++; if (lat !== 1) begin bad++; $display("FAIL rej_lat got=%0d exp=1", lat); end
    total++; if (er !== 1'b1) begin bad++; $display("FAIL rej_err got=%b exp=1", er); end
    total++; if (rd !== 32'h5A5A1234) begin bad++; $display("FAIL rej_rdata_kept got=%h exp=5a5a1234", rd); end
    @(negedge clk);
    total++; if (nvalid_b - nv !== 0) begin bad++; $display("FAIL rej_no_mem_valid got=%0d exp=0", nvalid_b - nv); end
  endtask

  task automatic test_midreset();
    int n, base, seen; int lat; logic [31:0] rd; logic er;
    tb_wait = 3;
    base = nbeat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h202; req_wdata = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (nbeat - base < 1 && n < 30) begin @(negedge clk); n++; end
    total++; if (mem_addr !== 32'h204) begin bad++; $display("FAIL midrst_in_beat1 got=%h exp=204", mem_addr); end
    resetn = 1'b0;
    @(negedge clk);
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL midrst_mem_valid got=%b exp=0", mem_valid); end
    seen = rsp_valid ? 1 : 0;
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (rsp_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_rsp got=%0d exp=0", seen); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
    tb_wait = 0; rd_addr1 = 32'h100; rd_data1 = 32'hDEADBEEF;
    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er);
    total++; if (lat !== 2) begin bad++; $display("FAIL post_rst_lat got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL post_rst_rdata got=%h exp=deadbeef", rd); end
  endtask

  initial begin
    resetn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_size_b = 2'd0; req_signed_b = 1'b0;
    req_addr_b = 32'h0; req_wdata_b = 32'h0;
    rd_addr1 = 32'h0; rd_data1 = 32'h0; rd_data0 = 32'h0; rdata_b = 32'h0;
    test_reset();
    test_aligned_load();
    test_signed_byte();
    test_store();
    test_wrap();
    test_reject();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
